oldland_cpuid_perf: RTL and testbench
=====================================

Name: oldland_cpuid_perf

Overview:
- Second-generation CPUID block: registered, handshaked register bank behind the control-register interface.
- Returns static CPU identification and cache/TLB geometry words.
- Adds 64-bit free-running performance counters (cycles, retired instructions) with a software enable/clear control register and a coherent hi/lo snapshot read.
- Sits beside the core's control-register decode; the core issues req and waits for ack.

Parameters:
- cpuid_manufacturer, 0, 16-bit manufacturer ID.
- cpuid_model, 0, 16-bit model ID.
- cpu_clock_speed, 0, core clock in Hz (32 bits).
- icache_size / icache_line_size / icache_num_ways, 0/4/1, I-cache bytes / bytes per line / ways.
- dcache_size / dcache_line_size / dcache_num_ways, 0/4/1, D-cache bytes / bytes per line / ways.
- itlb_num_entries / dtlb_num_entries, 0/0, TLB entry counts.
- CNT_WIDTH, 64, counter width; legal range 33..64.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request, sampled each rising edge.
- wr  in  1  1 = write, 0 = read; qualified by req.
- reg_sel  in  4  register index.
- wdata  in  32  write data.
- inst_retired  in  1  one pulse per retired instruction.
- stall  in  1  pipeline stalled this cycle (used only with the optional feature).
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid while ack = 1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: ack = 0, rdata = 0, all counters = 0, shadow registers = 0, ctrl.enable = 1.
- Handshake:
  - Every cycle with req = 1 is accepted.
  - ack = 1 and rdata are presented exactly one cycle after acceptance.
  - Back-to-back requests produce back-to-back acks.
  - Writes also ack; rdata = 0 on write acks.
  - Reset asserted while an ack is pending cancels it.
- Register map:
  - 0: {manufacturer, model}.
  - 1: clock speed.
  - 2: 0.
  - 3: {icache ways[7:0], icache lines[15:0], icache line words[7:0]}, where lines = size / line_size and line words = line_size / 4.
  - 4: same layout for the D-cache.
  - 5: {8'b0, itlb[7:0], 8'b0, dtlb[7:0]}.
  - 6: cycle counter low.
  - 7: cycle counter high shadow.
  - 8: retired counter low.
  - 9: retired counter high shadow.
  - 10: control — bit0 enable (R/W); bit1 clear (write-1 pulse, reads 0).
  - 11-15: read 0.
  - Writes to any register other than 10 are ignored.
- Counters:
  - Cycle counter increments every clk while enable = 1.
  - Retired counter increments on cycles where enable = 1 and inst_retired = 1.
  - Both wrap from all-ones to 0 silently.
  - Upper bits above CNT_WIDTH read 0.
- Snapshot:
  - A read of a low register returns the counter value held at the accepting edge.
  - The same edge loads the high shadow with the upper half of that same value.
  - A high read returns the shadow only; it never reads the live counter.
- Simultaneous events:
  - Clear write has priority over increment: the counter is 0 on the following cycle.
  - A clear write with bit0 = 0 clears and disables in the same write.
  - A low read in the clear cycle returns the pre-clear value.

Optional Feature:
- Macro: OLDLAND_CPUID_STALL_CNT_EN.
- Defined:
  - A third counter increments when enable = 1 and stall = 1.
  - Readable at 11 (low) and 12 (high shadow), with identical snapshot and clear rules.
- Undefined:
  - stall is ignored, registers 11/12 read 0, and no counter logic is instantiated.

Decomposition:
- Package oldland_cpuid_pkg:
  - Register index constants (CPUID_REG_ID0 .. CPUID_REG_CTRL).
  - Control bit positions (CTRL_ENABLE_BIT = 0, CTRL_CLEAR_BIT = 1).
  - Default CNT_WIDTH.
- Sub-module oldland_perf_counter:
  - CNT_WIDTH counter with inc, clr, snap inputs.
  - Outputs: lo, hi_shadow.
  - Instantiated 2 times, or 3 times when the macro is defined.

Test Plan:
- ID read: icache 8192 / 32 / 2 ways; read reg 3 -> ack after 1 cycle, rdata = 0x02010008. Read reg 14 -> 0.
- Snapshot: preload the cycle counter to 0x00000001_FFFFFFFF (force). Read reg 6 -> 0xFFFFFFFF; next cycle read reg 7 -> 0x00000001, despite the low half having wrapped in between.
- Clear vs increment: write reg 10 = 0x3 -> next-cycle counter = 0 and counting resumes. Write 0x2 -> counter stays 0 and enable = 0; a reg 6 read 5 cycles later -> 0.
- Retired count: enable = 1; 7 inst_retired pulses interleaved with gaps -> reg 8 = 7, reg 9 = 0. With enable = 0, further pulses leave the count at 7.
- Handshake and reset: req held 4 cycles -> 4 consecutive ack pulses. Assert rst on the cycle after a req -> no ack; rdata = 0; reg 10 reads back 0x1.
- Macro: with OLDLAND_CPUID_STALL_CNT_EN, 3 stall cycles -> reg 11 = 3. Without it -> reg 11 = 0.

Source files
------------

// File: rtl/oldland_cpuid_pkg.sv
// oldland_cpuid_pkg: register map, control bit positions and counter width default
// shared by the CPUID/perf-counter block and its counters.
package oldland_cpuid_pkg;
    localparam logic [3:0] CPUID_REG_ID0      = 4'd0;
    localparam logic [3:0] CPUID_REG_CLOCK    = 4'd1;
    localparam logic [3:0] CPUID_REG_RSVD     = 4'd2;
    localparam logic [3:0] CPUID_REG_ICACHE   = 4'd3;
    localparam logic [3:0] CPUID_REG_DCACHE   = 4'd4;
    localparam logic [3:0] CPUID_REG_TLB      = 4'd5;
    localparam logic [3:0] CPUID_REG_CYC_LO   = 4'd6;
    localparam logic [3:0] CPUID_REG_CYC_HI   = 4'd7;
    localparam logic [3:0] CPUID_REG_RET_LO   = 4'd8;
    localparam logic [3:0] CPUID_REG_RET_HI   = 4'd9;
    localparam logic [3:0] CPUID_REG_CTRL     = 4'd10;
    localparam logic [3:0] CPUID_REG_STALL_LO = 4'd11;
    localparam logic [3:0] CPUID_REG_STALL_HI = 4'd12;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CPUID_CNT_WIDTH = 64;
endpackage

// File: rtl/oldland_perf_counter.sv
// oldland_perf_counter: wrapping event counter with clear-over-increment priority
// and a high-half shadow loaded on snap so hi/lo reads stay coherent.
module oldland_perf_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi_shadow <= '0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (inc)
                cnt <= cnt + CNT_WIDTH'(1);
            // shadow takes the pre-update value, matching what the low read returns
            if (snap)
                hi_shadow <= 32'(cnt >> 32);
        end
    end

    assign lo = cnt[31:0];
endmodule

// File: rtl/oldland_cpuid_perf.sv
// oldland_cpuid_perf: registered CPUID bank with cycle/retired perf counters.
// Define OLDLAND_CPUID_STALL_CNT_EN to add a stall counter at registers 11/12.
module oldland_cpuid_perf
    import oldland_cpuid_pkg::*;
#(
    parameter logic [15:0] cpuid_manufacturer = 16'h0,
    parameter logic [15:0] cpuid_model        = 16'h0,
    parameter logic [31:0] cpu_clock_speed    = 32'h0,
    parameter int unsigned icache_size        = 0,
    parameter int unsigned icache_line_size   = 4,
    parameter int unsigned icache_num_ways    = 1,
    parameter int unsigned dcache_size        = 0,
    parameter int unsigned dcache_line_size   = 4,
    parameter int unsigned dcache_num_ways    = 1,
    parameter int unsigned itlb_num_entries   = 0,
    parameter int unsigned dtlb_num_entries   = 0,
    parameter int          CNT_WIDTH          = CPUID_CNT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  reg_sel,
    input  logic [31:0] wdata,
    input  logic        inst_retired,
    input  logic        stall,
    output logic        ack,
    output logic [31:0] rdata
);
    localparam logic [31:0] ICACHE_WORD = {8'(icache_num_ways), 16'(icache_size / icache_line_size),
                                           8'(icache_line_size / 4)};
    localparam logic [31:0] DCACHE_WORD = {8'(dcache_num_ways), 16'(dcache_size / dcache_line_size),
                                           8'(dcache_line_size / 4)};
    localparam logic [31:0] TLB_WORD    = {8'h0, 8'(itlb_num_entries), 8'h0, 8'(dtlb_num_entries)};

    logic        en;
    logic        rd;
    logic        wr_ctrl;
    logic        clr;
    logic [31:0] cyc_lo, cyc_hi, ret_lo, ret_hi, stl_lo, stl_hi;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign rd      = req & ~wr;
    assign wr_ctrl = req & wr & (reg_sel == CPUID_REG_CTRL);
    assign clr     = wr_ctrl & wdata[CTRL_CLEAR_BIT];

    oldland_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cyc (
        .clk(clk), .rst(rst), .inc(en), .clr(clr),
        .snap(rd & (reg_sel == CPUID_REG_CYC_LO)), .lo(cyc_lo), .hi_shadow(cyc_hi)
    );

    oldland_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ret (
        .clk(clk), .rst(rst), .inc(en & inst_retired), .clr(clr),
        .snap(rd & (reg_sel == CPUID_REG_RET_LO)), .lo(ret_lo), .hi_shadow(ret_hi)
    );

`ifdef OLDLAND_CPUID_STALL_CNT_EN
    oldland_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stl (
        .clk(clk), .rst(rst), .inc(en & stall), .clr(clr),
        .snap(rd & (reg_sel == CPUID_REG_STALL_LO)), .lo(stl_lo), .hi_shadow(stl_hi)
    );
    assign unused_bits = ^wdata[31:2];
`else
    assign stl_lo      = '0;
    assign stl_hi      = '0;
    assign unused_bits = ^{stall, wdata[31:2]};
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            CPUID_REG_ID0:      rd_mux = {cpuid_manufacturer, cpuid_model};
            CPUID_REG_CLOCK:    rd_mux = cpu_clock_speed;
            CPUID_REG_ICACHE:   rd_mux = ICACHE_WORD;
            CPUID_REG_DCACHE:   rd_mux = DCACHE_WORD;
            CPUID_REG_TLB:      rd_mux = TLB_WORD;
            CPUID_REG_CYC_LO:   rd_mux = cyc_lo;
            CPUID_REG_CYC_HI:   rd_mux = cyc_hi;
            CPUID_REG_RET_LO:   rd_mux = ret_lo;
            CPUID_REG_RET_HI:   rd_mux = ret_hi;
            CPUID_REG_CTRL:     rd_mux = {31'h0, en};
            CPUID_REG_STALL_LO: rd_mux = stl_lo;
            CPUID_REG_STALL_HI: rd_mux = stl_hi;
            default:            rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
            en    <= 1'b1;
        end else begin
            ack   <= req;
            rdata <= rd ? rd_mux : '0;
            if (wr_ctrl)
                en <= wdata[CTRL_ENABLE_BIT];
        end
    end
endmodule

// File: tb/tb_oldland_cpuid_perf.sv
// tb_oldland_cpuid_perf: directed plus randomized checks against a behavioural
// register-bank model; covers OLDLAND_CPUID_STALL_CNT_EN in either build.
module tb_oldland_cpuid_perf;
    localparam logic [15:0] MANUF   = 16'h4f4c;
    localparam logic [15:0] MODEL   = 16'h0002;
    localparam logic [31:0] CLK_HZ  = 32'd50_000_000;
    localparam int IC_SIZE = 8192, IC_LINE = 32, IC_WAYS = 2;
    localparam int DC_SIZE = 16384, DC_LINE = 64, DC_WAYS = 4;
    localparam int ITLB = 8, DTLB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  reg_sel = '0;
    logic [31:0] wdata = '0;
    logic        inst_retired = 1'b0;
    logic        stall = 1'b0;
    logic        ack;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    longint unsigned m_cyc, m_ret, m_stl;
    logic [31:0]     m_cyc_sh, m_ret_sh, m_stl_sh;
    bit              m_en;
    logic [31:0]     last_rd;
    int              acks;

    oldland_cpuid_perf #(
        .cpuid_manufacturer(MANUF), .cpuid_model(MODEL), .cpu_clock_speed(CLK_HZ),
        .icache_size(IC_SIZE), .icache_line_size(IC_LINE), .icache_num_ways(IC_WAYS),
        .dcache_size(DC_SIZE), .dcache_line_size(DC_LINE), .dcache_num_ways(DC_WAYS),
        .itlb_num_entries(ITLB), .dtlb_num_entries(DTLB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .reg_sel(reg_sel), .wdata(wdata),
        .inst_retired(inst_retired), .stall(stall), .ack(ack), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_ret = 0; m_stl = 0;
        m_cyc_sh = 0; m_ret_sh = 0; m_stl_sh = 0;
        m_en = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] s);
        case (s)
            4'd0:  return {MANUF, MODEL};
            4'd1:  return CLK_HZ;
            4'd3:  return {8'(IC_WAYS), 16'(IC_SIZE / IC_LINE), 8'(IC_LINE / 4)};
            4'd4:  return {8'(DC_WAYS), 16'(DC_SIZE / DC_LINE), 8'(DC_LINE / 4)};
            4'd5:  return {8'h0, 8'(ITLB), 8'h0, 8'(DTLB)};
            4'd6:  return m_cyc[31:0];
            4'd7:  return m_cyc_sh;
            4'd8:  return m_ret[31:0];
            4'd9:  return m_ret_sh;
            4'd10: return {31'h0, m_en};
`ifdef OLDLAND_CPUID_STALL_CNT_EN
            4'd11: return m_stl[31:0];
            4'd12: return m_stl_sh;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // one clock: drive at negedge, advance the model, check #1 after posedge
    task automatic step(input bit r, input bit w, input logic [3:0] s, input logic [31:0] d,
                        input bit ir, input bit st);
        bit          rdq, clrq;
        logic [31:0] er;
        req = r; wr = w; reg_sel = s; wdata = d; inst_retired = ir; stall = st;
        rdq  = r && !w;
        clrq = r && w && s == 4'd10 && d[1];
        er   = rdq ? model_read(s) : 32'h0;
        if (rdq && s == 4'd6)  m_cyc_sh = m_cyc[63:32];
        if (rdq && s == 4'd8)  m_ret_sh = m_ret[63:32];
        if (rdq && s == 4'd11) m_stl_sh = m_stl[63:32];
        m_cyc = clrq ? 0 : m_cyc + (m_en ? 1 : 0);
        m_ret = clrq ? 0 : m_ret + ((m_en && ir) ? 1 : 0);
        m_stl = clrq ? 0 : m_stl + ((m_en && st) ? 1 : 0);
        if (r && w && s == 4'd10) m_en = d[0];
        @(posedge clk);
        #1;
        check("ack", {31'h0, ack}, {31'h0, r});
        if (r) check($sformatf("rdata_r%0d", s), rdata, er);
        last_rd = rdata;
        if (ack) acks++;
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [3:0] s);
        step(1, 0, s, 32'h0, 0, 0);
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        step(1, 1, 4'd10, d, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'h0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_ack", {31'h0, ack}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rd_reg(4'd10);
        check("ctrl_after_reset", last_rd, 32'h1);
        rd_reg(4'd3);
        check("icache_word", last_rd, 32'h02010008);
        rd_reg(4'd14);
        check("reg14_zero", last_rd, 32'h0);
        rd_reg(4'd0);
        rd_reg(4'd1);
        rd_reg(4'd4);
        rd_reg(4'd5);

        force dut.u_cyc.cnt = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.u_cyc.cnt;
        m_cyc = 64'h0000_0001_FFFF_FFFF;
        rd_reg(4'd6);
        check("snap_lo", last_rd, 32'hFFFF_FFFF);
        rd_reg(4'd7);
        check("snap_hi", last_rd, 32'h1);

        wr_ctrl(32'h3);
        rd_reg(4'd6);
        check("clear_lo", last_rd, 32'h0);
        rd_reg(4'd6);
        check("resume_lo", last_rd, 32'h1);
        wr_ctrl(32'h2);
        idle(5);
        rd_reg(4'd6);
        check("clear_disable_lo", last_rd, 32'h0);
        rd_reg(4'd10);
        check("ctrl_disabled", last_rd, 32'h0);

        wr_ctrl(32'h3);
        for (int i = 0; i < 14; i++) step(0, 0, 4'd0, 32'h0, (i % 2) == 0, 0);
        rd_reg(4'd8);
        check("retired_lo", last_rd, 32'd7);
        rd_reg(4'd9);
        check("retired_hi", last_rd, 32'h0);
        wr_ctrl(32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 32'h0, 1, 0);
        rd_reg(4'd8);
        check("retired_frozen", last_rd, 32'd7);

        wr_ctrl(32'h3);
        acks = 0;
        for (int i = 0; i < 4; i++) rd_reg(4'($urandom_range(0, 15)));
        idle(1);
        check("b2b_acks", acks, 32'd4);

        wr_ctrl(32'h3);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 32'h0, 0, 1);
        wr_ctrl(32'h0);
        rd_reg(4'd11);
`ifdef OLDLAND_CPUID_STALL_CNT_EN
        check("stall_lo", last_rd, 32'd3);
`else
        check("stall_lo", last_rd, 32'd0);
`endif
        wr_ctrl(32'h1);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d    = $urandom;
            d[0] = $urandom_range(0, 3) != 0;
            d[1] = $urandom_range(0, 7) == 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
                 d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        req = 1'b1; wr = 1'b0; reg_sel = 4'd0; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cancel_ack", {31'h0, ack}, 32'h0);
        check("rst_cancel_rdata", rdata, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd_reg(4'd10);
        check("ctrl_after_rst", last_rd, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
